// File: rtl/uart_apb_driver_if.sv
// APB bus bundle between the UART driver (master) and a 16550-style UART slave.
interface uart_apb_driver_if;
   logic        psel;
   logic        penable;
   logic        pready;
   logic [11:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pwstrb;
   logic [31:0] prdata;
   logic        pslverr;

   modport master (
      output psel, penable, paddr, pwrite, pwdata, pwstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pwdata, pwstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/uart_apb_driver.sv
// APB initiator for a 16550-style UART: programs the line settings after reset,
// then polls LSR and moves bytes between the tx/rx streams and THR/RHR.
module uart_apb_driver #(
   parameter logic [15:0] DIV_CONST = 16'h0010,
   parameter logic [7:0]  LCR_VAL   = 8'h03,
   parameter logic [7:0]  FCR_VAL   = 8'h07,
   parameter logic [7:0]  IER_VAL   = 8'h00
) (
   input  logic                     clk,
   input  logic                     rst,
   uart_apb_driver_if.master        apb,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [7:0]               tx_data,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [7:0]               rx_data,
   output logic                     init_done,
   output logic                     apb_err
);

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_POLL   = 3'd1,
      ST_DECIDE = 3'd2,
      ST_RD_RHR = 3'd3,
      ST_WR_THR = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_SETUP  = 2'd1,
      PH_ACCESS = 2'd2
   } phase_e;

   // Register index of each init write: LCR(DLAB), DLL, DLM, LCR, FCR, IER.
   function automatic logic [2:0] init_reg(input logic [2:0] step);
      case (step)
         3'd0:    init_reg = 3'd3;
         3'd1:    init_reg = 3'd0;
         3'd2:    init_reg = 3'd1;
         3'd3:    init_reg = 3'd3;
         3'd4:    init_reg = 3'd2;
         3'd5:    init_reg = 3'd1;
         default: init_reg = 3'd3;
      endcase
   endfunction

   // Data byte of each init write; the final LCR write clears DLAB.
   function automatic logic [7:0] init_byte(input logic [2:0] step);
      case (step)
         3'd0:    init_byte = 8'h80;
         3'd1:    init_byte = DIV_CONST[7:0];
         3'd2:    init_byte = DIV_CONST[15:8];
         3'd3:    init_byte = LCR_VAL & 8'h7F;
         3'd4:    init_byte = FCR_VAL;
         3'd5:    init_byte = IER_VAL;
         default: init_byte = 8'h00;
      endcase
   endfunction

   // Byte lane selected by the low address bits.
   function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] lane);
      case (lane)
         2'd0:    lane_byte = d[7:0];
         2'd1:    lane_byte = d[15:8];
         2'd2:    lane_byte = d[23:16];
         2'd3:    lane_byte = d[31:24];
         default: lane_byte = 8'h00;
      endcase
   endfunction

   state_e      state_q, state_d;
   phase_e      phase_q, phase_d;
   logic [2:0]  step_q, step_d;
   logic        lsr_dr_q, lsr_dr_d;
   logic        lsr_thre_q, lsr_thre_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic [11:0] paddr_q, paddr_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [3:0]  pwstrb_q, pwstrb_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        init_done_q, init_done_d;
   logic        apb_err_q, apb_err_d;

   logic [2:0]  req_idx_s;
   logic        req_wr_s;
   logic [7:0]  req_byte_s;
   logic        done_s;
   logic [7:0]  rd_byte_s;

   assign done_s    = (phase_q == PH_ACCESS) && apb.pready;
   assign rd_byte_s = lane_byte(apb.prdata, paddr_q[1:0]);

   // Transfer request (register, direction, byte) implied by the current state.
   always_comb begin
      req_idx_s  = 3'd5;
      req_wr_s   = 1'b0;
      req_byte_s = 8'h00;
      case (state_q)
         ST_INIT: begin
            req_idx_s  = init_reg(step_q);
            req_wr_s   = 1'b1;
            req_byte_s = init_byte(step_q);
         end
         ST_POLL:   req_idx_s = 3'd5;
         ST_RD_RHR: req_idx_s = 3'd0;
         ST_WR_THR: begin
            req_idx_s  = 3'd0;
            req_wr_s   = 1'b1;
            req_byte_s = tx_data;
         end
         default:   req_idx_s = 3'd5;
      endcase
   end

   // Next-state logic for the sequencer, the APB phase and all registered outputs.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      step_d      = step_q;
      lsr_dr_d    = lsr_dr_q;
      lsr_thre_d  = lsr_thre_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pwstrb_d    = pwstrb_q;
      rx_data_d   = rx_data_q;
      init_done_d = init_done_q;
      apb_err_d   = apb_err_q;

      // Consumer handshake drops rx_valid regardless of the sequencer state.
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end

      case (phase_q)
         PH_IDLE: begin
            if (state_q == ST_DECIDE) begin
               // DR wins over THRE; a held rx byte blocks further RHR reads.
               if (lsr_dr_q && !rx_valid_q) begin
                  state_d = ST_RD_RHR;
               end else if (lsr_thre_q && tx_valid) begin
                  state_d = ST_WR_THR;
               end else begin
                  state_d = ST_POLL;
               end
            end else begin
               // Launch SETUP; tx_data is captured here and held to completion.
               psel_d    = 1'b1;
               penable_d = 1'b0;
               phase_d   = PH_SETUP;
               paddr_d   = {9'b0_0000_0000, req_idx_s};
               pwrite_d  = req_wr_s;
               pwdata_d  = req_wr_s ? {4{req_byte_s}} : 32'h0000_0000;
               pwstrb_d  = req_wr_s ? (4'b0001 << req_idx_s[1:0]) : 4'b0000;
            end
         end
         PH_SETUP: begin
            penable_d = 1'b1;
            phase_d   = PH_ACCESS;
         end
         PH_ACCESS: begin
            if (apb.pready) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               phase_d   = PH_IDLE;
               if (apb.pslverr) begin
                  apb_err_d = 1'b1;
               end else begin
                  apb_err_d = apb_err_q;
               end
               case (state_q)
                  ST_INIT: begin
                     if (step_q == 3'd5) begin
                        step_d      = 3'd0;
                        init_done_d = 1'b1;
                        state_d     = ST_POLL;
                     end else begin
                        step_d = step_q + 3'd1;
                     end
                  end
                  ST_POLL: begin
                     // An errored LSR read reads as all-zero status.
                     lsr_dr_d   = apb.pslverr ? 1'b0 : rd_byte_s[0];
                     lsr_thre_d = apb.pslverr ? 1'b0 : rd_byte_s[5];
                     state_d    = ST_DECIDE;
                  end
                  ST_RD_RHR: begin
                     rx_data_d  = rd_byte_s;
                     rx_valid_d = 1'b1;
                     state_d    = ST_POLL;
                  end
                  ST_WR_THR: state_d = ST_POLL;
                  default:   state_d = ST_POLL;
               endcase
            end else begin
               phase_d = PH_ACCESS;
            end
         end
         default: begin
            phase_d   = PH_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   // Sequencer and output registers; synchronous reset aborts any transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         phase_q     <= PH_IDLE;
         step_q      <= 3'd0;
         lsr_dr_q    <= 1'b0;
         lsr_thre_q  <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= 12'h000;
         pwrite_q    <= 1'b0;
         pwdata_q    <= 32'h0000_0000;
         pwstrb_q    <= 4'b0000;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         init_done_q <= 1'b0;
         apb_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         step_q      <= step_d;
         lsr_dr_q    <= lsr_dr_d;
         lsr_thre_q  <= lsr_thre_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pwstrb_q    <= pwstrb_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         init_done_q <= init_done_d;
         apb_err_q   <= apb_err_d;
      end
   end

   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.pwdata  = pwdata_q;
   assign apb.pwstrb  = pwstrb_q;
   assign rx_valid    = rx_valid_q;
   assign rx_data     = rx_data_q;
   assign init_done   = init_done_q;
   assign apb_err     = apb_err_q;
   // tx_ready must mark the THR completion cycle itself, so it follows pready.
   assign tx_ready    = (state_q == ST_WR_THR) && done_s;

endmodule

// File: tb/tb_uart_apb_driver.sv
// Directed bench for uart_apb_driver with a reactive APB UART slave model.
module tb_uart_apb_driver;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] tx_data = 8'h00;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       init_done;
   logic       apb_err;

   logic [7:0] lsr_val = 8'h00;
   logic [7:0] rhr_val = 8'h00;
   logic       ws_mode = 1'b0;
   int         ws_cnt = 0;
   int         ws_max = 0;
   int         txr_cnt = 0;
   int         stab_err = 0;
   int         total = 0;
   int         bad = 0;

   typedef struct {
      logic [11:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        idone;
   } txn_t;
   txn_t q[$];

   logic [11:0] s_addr = 12'h000;
   logic        s_wr = 1'b0;
   logic [31:0] s_wdata = 32'h0;
   logic [3:0]  s_strb = 4'h0;

   always #5 clk = ~clk;

   uart_apb_driver_if apb_if ();

   uart_apb_driver #(.DIV_CONST(16'h1234)) dut (
      .clk(clk), .rst(rst), .apb(apb_if),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .init_done(init_done), .apb_err(apb_err)
   );

   // Slave: reg 5 = LSR, anything else reads RHR; byte placed on its own lane only.
   assign apb_if.pready  = !(ws_mode && apb_if.pwrite && apb_if.penable && (ws_cnt < 3));
   assign apb_if.pslverr = ws_mode && apb_if.pwrite;
   assign apb_if.prdata  = {24'h0, (apb_if.paddr[2:0] == 3'd5) ? lsr_val : rhr_val}
                           << {apb_if.paddr[1:0], 3'b000};

   // Wait-state counter and longest stall seen.
   always @(posedge clk) begin
      if (rst) begin
         ws_cnt <= 0;
      end else if (apb_if.psel && apb_if.penable && !apb_if.pready) begin
         ws_cnt <= ws_cnt + 1;
         if (ws_cnt + 1 > ws_max) ws_max <= ws_cnt + 1;
      end else begin
         ws_cnt <= 0;
      end
   end

   // Bus monitor: completed transfers, tx_ready pulses, SETUP-to-ACCESS stability.
   always @(posedge clk) begin
      if (!rst) begin
         if (apb_if.psel && !apb_if.penable) begin
            s_addr  <= apb_if.paddr;
            s_wr    <= apb_if.pwrite;
            s_wdata <= apb_if.pwdata;
            s_strb  <= apb_if.pwstrb;
         end
         if (apb_if.psel && apb_if.penable &&
             ({apb_if.paddr, apb_if.pwrite, apb_if.pwdata, apb_if.pwstrb} !==
              {s_addr, s_wr, s_wdata, s_strb}))
            stab_err <= stab_err + 1;
         if (apb_if.psel && apb_if.penable && apb_if.pready)
            q.push_back('{apb_if.paddr, apb_if.pwrite, apb_if.pwdata, apb_if.pwstrb, init_done});
         if (tx_ready) txr_cnt <= txr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_txn(input int n, input string tag);
      int b = 0;
      while (q.size() < n && b < 3000) begin
         @(negedge clk);
         b++;
      end
      if (q.size() < n) chk(tag, q.size(), n);
   endtask

   task automatic wait_txr(input int base, input string tag);
      int b = 0;
      while (txr_cnt <= base && b < 3000) begin
         @(negedge clk);
         b++;
      end
      if (txr_cnt <= base) chk(tag, txr_cnt, base + 1);
   endtask

   logic [11:0] exp_addr [6] = '{12'd3, 12'd0, 12'd1, 12'd3, 12'd2, 12'd1};
   logic [7:0]  exp_byte [6] = '{8'h80, 8'h34, 8'h12, 8'h03, 8'h07, 8'h00};
   logic [3:0]  exp_strb [6] = '{4'h8, 4'h1, 4'h2, 4'h8, 4'h4, 4'h2};

   initial begin
      int base;
      int nw;
      int wi;
      int r;
      int b;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.pwstrb}, 32'h0);
      chk("rst_paddr", apb_if.paddr, 32'h0);
      chk("rst_pwdata", apb_if.pwdata, 32'h0);
      chk("rst_flags", {tx_ready, rx_valid, init_done, apb_err}, 32'h0);
      chk("rst_rxdata", rx_data, 32'h0);

      // Init sequence
      rst = 1'b0;
      wait_txn(6, "init_timeout");
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("init%0d_addr", i), q[i].addr, exp_addr[i]);
         chk($sformatf("init%0d_wr", i), q[i].wr, 32'h1);
         chk($sformatf("init%0d_wdata", i), q[i].wdata, {4{exp_byte[i]}});
         chk($sformatf("init%0d_strb", i), q[i].strb, exp_strb[i]);
      end
      chk("init_done_at_last", q[5].idone, 32'h0);
      chk("init_done_after", init_done, 32'h1);

      // Idle polling: LSR reads only
      q.delete();
      wait_txn(3, "poll_timeout");
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("poll%0d_addr", i), q[i].addr, 32'h5);
         chk($sformatf("poll%0d_wrstrb", i), {q[i].wr, q[i].strb}, 32'h0);
      end

      // TX: one THR write per observed THRE
      q.delete();
      lsr_val = 8'h60; tx_data = 8'h41; tx_valid = 1'b1;
      base = txr_cnt;
      wait_txr(base, "tx_timeout");
      tx_valid = 1'b0;
      wait_txn(q.size() + 4, "tx_tail_timeout");
      nw = 0; wi = 0;
      foreach (q[i]) if (q[i].wr) begin nw++; wi = i; end
      chk("tx_nwrites", nw, 32'h1);
      chk("tx_addr", q[wi].addr, 32'h0);
      chk("tx_wdata", q[wi].wdata, 32'h41414141);
      chk("tx_strb", q[wi].strb, 32'h1);
      chk("tx_pulses", txr_cnt - base, 32'h1);
      lsr_val = 8'h00;

      // RX with backpressure
      lsr_val = 8'h61; rhr_val = 8'h5A; rx_ready = 1'b0;
      b = 0;
      while (!rx_valid && b < 3000) begin @(negedge clk); b++; end
      chk("rx_valid_up", rx_valid, 32'h1);
      chk("rx_data", rx_data, 32'h5A);
      q.delete();
      wait_txn(8, "rx_bp_timeout");
      nw = 0;
      foreach (q[i]) if (q[i].addr == 12'd0) nw++;
      chk("rx_bp_no_rhr", nw, 32'h0);
      chk("rx_valid_held", rx_valid, 32'h1);
      lsr_val = 8'h00;
      rx_ready = 1'b1;
      @(negedge clk);
      chk("rx_valid_drop", rx_valid, 32'h0);
      rx_ready = 1'b0;

      // Priority: RHR read, LSR poll, then THR write
      q.delete();
      lsr_val = 8'h61; rhr_val = 8'hA5; tx_data = 8'h33; tx_valid = 1'b1;
      base = txr_cnt;
      wait_txr(base, "prio_timeout");
      tx_valid = 1'b0; lsr_val = 8'h00;
      r = -1;
      foreach (q[i]) if (r < 0 && q[i].addr == 12'd0) r = i;
      if (r >= 0 && q.size() >= r + 3) begin
         chk("prio_first_is_read", q[r].wr, 32'h0);
         chk("prio_mid_lsr", {q[r+1].addr, q[r+1].wr}, {12'd5, 1'b0});
         chk("prio_then_write", {q[r+2].addr, q[r+2].wr}, {12'd0, 1'b1});
         chk("prio_wdata", q[r+2].wdata, 32'h33333333);
      end else begin
         chk("prio_sequence_found", 32'h0, 32'h1);
      end
      chk("prio_rx_data", rx_data, 32'hA5);
      rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      rx_ready = 1'b0;
      chk("prio_rx_drained", rx_valid, 32'h0);

      // Wait states plus slave error on a THR write
      chk("err_clear_before", apb_err, 32'h0);
      q.delete();
      ws_mode = 1'b1; lsr_val = 8'h60; tx_data = 8'hC3; tx_valid = 1'b1;
      base = txr_cnt;
      wait_txr(base, "ws_timeout");
      tx_valid = 1'b0; ws_mode = 1'b0; lsr_val = 8'h00;
      chk("ws_len", ws_max, 32'd3);
      nw = 0; wi = 0;
      foreach (q[i]) if (q[i].wr) begin nw++; wi = i; end
      chk("ws_nwrites", nw, 32'h1);
      chk("ws_wdata", q[wi].wdata, 32'hC3C3C3C3);
      chk("ws_err_set", apb_err, 32'h1);
      wait_txn(q.size() + 5, "ws_tail_timeout");
      chk("ws_pulses", txr_cnt - base, 32'h1);
      chk("ws_err_sticky", apb_err, 32'h1);

      // Reset during ACCESS of the 4th init write
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q.delete();
      b = 0;
      while (!(q.size() == 3 && apb_if.psel && apb_if.penable) && b < 500) begin
         @(negedge clk); b++;
      end
      chk("mid_at_4th", {apb_if.paddr, apb_if.penable}, {12'd3, 1'b1});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_psel_low", apb_if.psel, 32'h0);
      chk("mid_init_done", init_done, 32'h0);
      chk("mid_err_cleared", apb_err, 32'h0);
      q.delete();
      wait_txn(1, "restart_timeout");
      chk("restart_addr", q[0].addr, 32'h3);
      chk("restart_wdata", q[0].wdata, 32'h80808080);
      wait_txn(6, "reinit_timeout");
      chk("reinit_done", init_done, 32'h1);

      chk("bus_stable", stab_err, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
